// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 response keypad scanner.
package keypad_pkg;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int CODE_W = 4;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_SINGLE,
      RES_MULTI
   } scan_res_e;

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESS_WAIT,
      ST_PRESSED,
      ST_RELEASE_WAIT
   } deb_state_e;

   // Columns are active-low, so closed keys show up as zero bits.
   function automatic logic [2:0] zero_count(input logic [COLS-1:0] col);
      logic [2:0] cnt;
      cnt = '0;
      for (int i = 0; i < COLS; i++) begin
         cnt = cnt + 3'(!col[i]);
      end
      return cnt;
   endfunction

   function automatic logic [1:0] first_zero(input logic [COLS-1:0] col);
      logic [1:0] idx;
      idx = '0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (!col[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release debounce FSM, evaluated once per completed keypad scan.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_done,
   input  scan_res_e         result,
   input  logic [CODE_W-1:0] result_code,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_down
);

   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1) + 1;
   localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_SCANS);

   deb_state_e        state_q;
   logic [CNT_W-1:0]  stab_q;
   logic [CODE_W-1:0] cand_q;
   logic [CODE_W-1:0] key_code_q;
   logic              key_valid_q;
   logic              key_down_q;

   logic              is_single;
   logic              is_none;
   logic [CNT_W-1:0]  stab_inc;

   assign is_single = (result == RES_SINGLE);
   assign is_none   = (result == RES_NONE);
   assign stab_inc  = stab_q + CNT_W'(1);

   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RELEASED;
         stab_q      <= '0;
         cand_q      <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         if (scan_done) begin
            unique case (state_q)
               ST_RELEASED: begin
                  if (is_single && DEBOUNCE_SCANS == 1) begin
                     state_q     <= ST_PRESSED;
                     key_code_q  <= result_code;
                     key_valid_q <= 1'b1;
                     key_down_q  <= 1'b1;
                  end else if (is_single) begin
                     state_q <= ST_PRESS_WAIT;
                     cand_q  <= result_code;
                     stab_q  <= CNT_W'(1);
                  end
               end
               ST_PRESS_WAIT: begin
                  if (is_single && result_code == cand_q) begin
                     if (stab_inc >= DEB) begin
                        state_q     <= ST_PRESSED;
                        key_code_q  <= cand_q;
                        key_valid_q <= 1'b1;
                        key_down_q  <= 1'b1;
                     end else begin
                        stab_q <= stab_inc;
                     end
                  end else if (is_single) begin
                     cand_q <= result_code;
                     stab_q <= CNT_W'(1);
                  end else if (!is_none) begin
                     stab_q <= '0;
                  end else begin
                     state_q <= ST_RELEASED;
                     stab_q  <= '0;
                  end
               end
               ST_PRESSED: begin
                  if (!(is_single && result_code == key_code_q)) begin
                     if (is_none && DEBOUNCE_SCANS == 1) begin
                        state_q    <= ST_RELEASED;
                        stab_q     <= '0;
                        key_down_q <= 1'b0;
                     end else begin
                        state_q <= ST_RELEASE_WAIT;
                        stab_q  <= CNT_W'(1);
                     end
                  end
               end
               ST_RELEASE_WAIT: begin
                  if (is_none) begin
                     if (stab_inc >= DEB) begin
                        state_q    <= ST_RELEASED;
                        stab_q     <= '0;
                        key_down_q <= 1'b0;
                     end else begin
                        stab_q <= stab_inc;
                     end
                  end else if (is_single && result_code == key_code_q) begin
                     state_q <= ST_PRESSED;
                  end else begin
                     stab_q <= CNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/matrix_keypad_scan.sv
// Row strobe scanner and per-scan column accumulator for the response keypad.
module matrix_keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [COLS-1:0]   col_in,
   output logic [ROWS-1:0]   row_out,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_down
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [1:0]        row_q, row_d;
   logic [1:0]        acc_cnt_q, acc_cnt_d;
   logic [CODE_W-1:0] acc_code_q, acc_code_d;
   logic              done_q, done_d;
   scan_res_e         res_q, res_d;
   logic [CODE_W-1:0] res_code_q, res_code_d;

   logic              slot_end;
   logic [2:0]        row_zeros;
   logic [2:0]        sum;
   logic [1:0]        base_cnt;

   assign slot_end = (slot_q == SLOT_LAST);
   assign row_out  = ~(4'b0001 << row_q);

   // Columns are folded in on the last slot cycle so they have settled;
   // the count saturates at 2 since only NONE/SINGLE/MULTI matter.
   always_comb begin
      slot_d     = slot_end ? '0 : slot_q + SLOT_W'(1);
      row_d      = slot_end ? row_q + 2'd1 : row_q;
      row_zeros  = zero_count(col_in);
      base_cnt   = (row_q == 2'd0) ? 2'd0 : acc_cnt_q;
      sum        = {1'b0, base_cnt} + row_zeros;
      acc_cnt_d  = acc_cnt_q;
      acc_code_d = acc_code_q;
      done_d     = 1'b0;
      res_d      = res_q;
      res_code_d = res_code_q;
      if (slot_end) begin
         acc_cnt_d = (sum > 3'd1) ? 2'd2 : sum[1:0];
         if (base_cnt == 2'd0) begin
            acc_code_d = {row_q, first_zero(col_in)};
         end
         if (row_q == 2'(ROWS - 1)) begin
            done_d     = 1'b1;
            res_code_d = acc_code_d;
            if (acc_cnt_d == 2'd0) begin
               res_d = RES_NONE;
            end else if (acc_cnt_d == 2'd1) begin
               res_d = RES_SINGLE;
            end else begin
               res_d = RES_MULTI;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q     <= '0;
         row_q      <= '0;
         acc_cnt_q  <= '0;
         acc_code_q <= '0;
         done_q     <= 1'b0;
         res_q      <= RES_NONE;
         res_code_q <= '0;
      end else begin
         slot_q     <= slot_d;
         row_q      <= row_d;
         acc_cnt_q  <= acc_cnt_d;
         acc_code_q <= acc_code_d;
         done_q     <= done_d;
         res_q      <= res_d;
         res_code_q <= res_code_d;
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .scan_done  (done_q),
      .result     (res_q),
      .result_code(res_code_q),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_down   (key_down)
   );

endmodule

// File: doc/matrix_keypad_scan.md
# matrix_keypad_scan

Scans a 4x4 passive key matrix for the vision tester's response keypad and reports debounced key presses to the test controller. The dot-matrix display drives rows and columns outward to show optotypes. This block works the other way round: it strobes the keypad rows and reads the columns back. It produces one single-cycle event per accepted press, with a 4-bit key code, plus a key-held level.

## Interface
- SCAN_DIV, 1000: clk cycles each row stays driven (row slot length); minimum 2.
- DEBOUNCE_SCANS, 8: consecutive identical full-scan results required to change the accepted state; minimum 1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset; one clock domain only.
- col_in  input  4  keypad columns, active-low (board pull-ups); col_in[c]=0 means a key in the driven row and column c is closed.
- row_out  output  4  keypad row strobe, active-low one-cold; exactly one bit is low at all times.
- key_code  output  4  accepted key index = row*4 + col; holds its last value after release.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- key_down  output  1  high while the accepted state is "key held".

## Operation
- Row scanner: slot counter 0..SCAN_DIV-1 and row pointer 0..3. The pointer advances, wrapping 3->0, when the slot counter wraps. row_out = ~(1 << row).
- Column sample: col_in is registered on the last cycle of each slot (slot counter = SCAN_DIV-1), which gives the lines SCAN_DIV-1 cycles to settle.
- Per-scan result, formed after the row 3 sample and reset at the start of the row 0 slot:
  - NONE: no zero bit in any row.
  - SINGLE(code): exactly one zero bit across all four rows.
  - MULTI: two or more zero bits in total.
- Debounce FSM (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT) is evaluated once per completed scan. Stability counter stab_cnt counts up to DEBOUNCE_SCANS.
  - RELEASED, SINGLE(k): go to PRESS_WAIT with candidate=k and stab_cnt=1.
  - RELEASED, NONE or MULTI: stay in RELEASED.
  - PRESS_WAIT, SINGLE(candidate): increment stab_cnt. On reaching DEBOUNCE_SCANS, go to PRESSED, load key_code=candidate, pulse key_valid, set key_down=1.
  - PRESS_WAIT, SINGLE(other): reload candidate, stab_cnt=1.
  - PRESS_WAIT, MULTI: stab_cnt=0, stay in PRESS_WAIT.
  - PRESS_WAIT, NONE: back to RELEASED.
  - PRESSED, any result other than SINGLE(key_code): go to RELEASE_WAIT with stab_cnt=1.
  - RELEASE_WAIT, NONE: increment stab_cnt. On reaching DEBOUNCE_SCANS, go to RELEASED and clear key_down.
  - RELEASE_WAIT, SINGLE(key_code): back to PRESSED. No new pulse.
  - RELEASE_WAIT, SINGLE(other) or MULTI: stab_cnt=1, stay in RELEASE_WAIT.
- DEBOUNCE_SCANS=1: a press is accepted on the first scan that yields SINGLE.
- A second key cannot produce an event until the accepted state has returned to RELEASED. Rollover is not supported.

## Timing
- Reset values (asynchronous, while rst=0): row_out=4'b1110, key_code=0, key_valid=0, key_down=0, slot/row counters=0, FSM=RELEASED, stab_cnt=0, scan accumulator cleared.
- Reset mid-scan: all state is discarded; scanning restarts at row 0, slot 0 on the first clk edge after rst deasserts.
- Scan period = 4*SCAN_DIV cycles.
- The FSM updates on the clk edge following the row 3 sample. key_valid and key_down change on that same edge, i.e. registered, 1 cycle after the final sample.
- Press latency, measured from the first scan whose samples all see the key: DEBOUNCE_SCANS scans plus 1 cycle.
- key_valid is high for exactly one cycle per accepted press and is never asserted at the same time as key_down falling.

## Structure
- Shared package keypad_pkg holds:
  - ROWS=4, COLS=4, CODE_W=4;
  - scan-result typedef (NONE, SINGLE, MULTI);
  - debounce state enum.
- Sub-module keypad_debounce contains the FSM and stab_cnt. Inputs: scan_done, result, result_code. Outputs: key_code, key_valid, key_down.
- The top level holds the row scanner, the column sampler and the per-scan accumulator.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, so one scan is 16 cycles.
- Reset: drive rst=0 during row 2 of a scan -> row_out=1110, key_code=0, key_valid=0 and key_down=0 immediately. After release, row_out steps 1110, 1101, 1011, 0111, holding each for 4 cycles.
- Clean press: hold the key at row 2 / col 1 (col_in[1]=0 only while row_out=1011) -> one key_valid pulse with key_code=9 after the 3rd full scan plus 1 cycle; key_down=1 from that edge.
- Bounce: key 9 alternates present/absent for 2 scans, then stays stable -> exactly one key_valid pulse, 3 stable scans after the bounce ends.
- Multi-key: hold keys 0 and 5 together from RELEASED -> no key_valid pulse; key_down and key_code stay 0.
- Release and repress: release key 9 -> key_down falls 3 NONE scans plus 1 cycle later, with no pulse. Press key 9 again -> a new pulse, key_code=9.
- Overlap: hold key 9 until accepted, add key 6 (MULTI), then release 9 leaving 6 -> no pulse while MULTI. Once 6 is alone, the FSM must pass through RELEASED before accepting 6, so the bench must release all keys for 3 NONE scans and then press key 6 alone -> pulse with key_code=6.
